// File: rtl/alu_bit_serial_seq_if.sv
// rtl/alu_bit_serial_seq_if.sv - request/response bundle of the bit-serial ALU sequencer
//
// Purpose: groups the operation request (start/ready plus operands and controls)
//          and the completion response (result, flags, done) of alu_bit_serial_seq.
// Signals:
//   start, ready            request handshake (accept when start && ready)
//   op_a, op_b [WIDTH]      operands
//   opsel [3], mode, cin_init  slice controls and initial carry
//   result [WIDTH], carry_out, zero, ovf, done  completion response
// Modports:
//   master  requester side (drives request, observes response)
//   slave   sequencer side
interface alu_bit_serial_seq_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [2:0]       opsel;
  logic             mode;
  logic             cin_init;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             zero;
  logic             ovf;
  logic             done;

  modport master (
    output start, op_a, op_b, opsel, mode, cin_init,
    input  ready, result, carry_out, zero, ovf, done
  );

  modport slave (
    input  start, op_a, op_b, opsel, mode, cin_init,
    output ready, result, carry_out, zero, ovf, done
  );
endinterface

// File: rtl/alu_bit_serial_seq.sv
// rtl/alu_bit_serial_seq.sv - bit-serial sequencer around a single-bit ALU slice
//
// Purpose: latches two WIDTH-bit operands on accept and walks them through one
//          external 1-bit ALU slice, LSB first, one bit per clock. The slice
//          carry-out is registered and fed back as the next carry-in; slice
//          result bits are shifted into a WIDTH-bit word. FSM IDLE -> RUN -> DONE.
// Parameters:
//   WIDTH  operand/result width, 1..64
// Ports:
//   clk, rst_n         clock (rising edge), synchronous active-low reset
//   bus (slave)        start/ready request, op_a/op_b/opsel/mode/cin_init,
//                      result/carry_out/zero/ovf held until next accept, done pulse
//   slice_op1/op2      current operand bits (a_sh[0], b_sh[0])
//   slice_cin          registered carry
//   slice_opsel/mode   latched controls
//   slice_result/cout  slice outputs, consumed in the same cycle
// Configuration:
//   ALU_SEQ_OVERFLOW_EN  when defined, ovf reports signed overflow of arithmetic
//                        ops; when undefined ovf is tied to 0.
module alu_bit_serial_seq #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_bit_serial_seq_if.slave bus,
  output logic                slice_op1,
  output logic                slice_op2,
  output logic                slice_cin,
  output logic [2:0]          slice_opsel,
  output logic                slice_mode,
  input  logic                slice_result,
  input  logic                slice_cout
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic             accept;
  logic             last;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [WIDTH-1:0] res_next;
  logic [CW-1:0]    cnt;
  logic             carry_q;
  logic [2:0]       opsel_q;
  logic             mode_q;
  logic [WIDTH-1:0] result_q;
  logic             carry_out_q;
  logic             zero_q;
  logic             ovf_q;

  assign last = (cnt == CW'(WIDTH - 1));

  // Incoming slice bit lands in the MSB; after WIDTH shifts bit 0 sits at the LSB.
  always_comb begin
    res_next            = res_sh >> 1;
    res_next[WIDTH-1]   = slice_result;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (last) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh        <= '0;
      b_sh        <= '0;
      res_sh      <= '0;
      cnt         <= '0;
      carry_q     <= 1'b0;
      opsel_q     <= 3'd0;
      mode_q      <= 1'b0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      zero_q      <= 1'b0;
    end else if (accept) begin
      a_sh    <= bus.op_a;
      b_sh    <= bus.op_b;
      opsel_q <= bus.opsel;
      mode_q  <= bus.mode;
      carry_q <= bus.cin_init;
      cnt     <= '0;
    end else if (state_q == S_RUN) begin
      a_sh    <= a_sh >> 1;
      b_sh    <= b_sh >> 1;
      res_sh  <= res_next;
      carry_q <= slice_cout;
      cnt     <= cnt + CW'(1);
      if (last) begin
        result_q    <= res_next;
        carry_out_q <= slice_cout;
        zero_q      <= (res_next == '0);
      end
    end
  end

`ifdef ALU_SEQ_OVERFLOW_EN
  // During the last RUN cycle carry_q is the carry into the MSB; signed
  // overflow is that carry disagreeing with the carry out of the MSB.
  logic carry_into_msb;
  assign carry_into_msb = carry_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (state_q == S_RUN && last) begin
      ovf_q <= !mode_q && (carry_into_msb ^ slice_cout);
    end
  end
`else
  assign ovf_q = 1'b0;
`endif

  assign slice_op1   = a_sh[0];
  assign slice_op2   = b_sh[0];
  assign slice_cin   = carry_q;
  assign slice_opsel = opsel_q;
  assign slice_mode  = mode_q;

  assign bus.ready     = (state_q == S_IDLE);
  assign bus.done      = (state_q == S_DONE);
  assign bus.result    = result_q;
  assign bus.carry_out = carry_out_q;
  assign bus.zero      = zero_q;
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_alu_bit_serial_seq.sv
// tb/tb_alu_bit_serial_seq.sv - self-checking bench for alu_bit_serial_seq
module tb_alu_bit_serial_seq;
  localparam int W = 8;
`ifdef ALU_SEQ_OVERFLOW_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       slice_op1;
  logic       slice_op2;
  logic       slice_cin;
  logic [2:0] slice_opsel;
  logic       slice_mode;
  logic       slice_result;
  logic       slice_cout;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_bit_serial_seq_if #(.WIDTH(W)) bus ();

  alu_bit_serial_seq #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .slice_op1    (slice_op1),
    .slice_op2    (slice_op2),
    .slice_cin    (slice_cin),
    .slice_opsel  (slice_opsel),
    .slice_mode   (slice_mode),
    .slice_result (slice_result),
    .slice_cout   (slice_cout)
  );

  // Slice model: mode 0 full adder, mode 1 AND with carry passed through.
  always_comb begin
    if (slice_mode == 1'b0) begin
      slice_result = slice_op1 ^ slice_op2 ^ slice_cin;
      slice_cout   = (slice_op1 & slice_op2) | (slice_op1 & slice_cin) | (slice_op2 & slice_cin);
    end else begin
      slice_result = slice_op1 & slice_op2;
      slice_cout   = slice_cin;
    end
  end

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] opsel;
    logic       mode;
    logic       cin;
    logic [7:0] res;
    logic       cout;
    logic       zero;
    logic       ovf;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic count_done(input int n, output int pulses);
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (bus.done) pulses++;
    end
  endtask

  task automatic run_op(input vec_t v, output int cycles,
                        output logic [2:0] seen_opsel, output logic seen_mode);
    bus.op_a     = v.a;
    bus.op_b     = v.b;
    bus.opsel    = v.opsel;
    bus.mode     = v.mode;
    bus.cin_init = v.cin;
    bus.start    = 1'b1;
    tick();
    // Scramble inputs after accept; the latched copy must be used.
    bus.start    = 1'b0;
    bus.op_a     = ~v.a;
    bus.op_b     = 8'($urandom);
    bus.opsel    = ~v.opsel;
    bus.mode     = ~v.mode;
    bus.cin_init = ~v.cin;
    seen_opsel   = slice_opsel;
    seen_mode    = slice_mode;
    cycles = 1;
    while (!bus.done && cycles < 40) begin
      tick();
      cycles++;
    end
  endtask

  initial begin
    int         cycles;
    int         pulses;
    logic [2:0] s_opsel;
    logic       s_mode;

    vecs[0] = '{8'h3C, 8'h0F, 3'd0, 1'b0, 1'b0, 8'h4B, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 3'd0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{8'h7F, 8'h01, 3'd0, 1'b0, 1'b0, 8'h80, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{8'h80, 8'h80, 3'd1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1};
    vecs[4] = '{8'h00, 8'h00, 3'd2, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{8'h55, 8'h55, 3'd3, 1'b0, 1'b0, 8'hAA, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{8'hF0, 8'h3C, 3'd4, 1'b1, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{8'hAA, 8'hFF, 3'd5, 1'b1, 1'b1, 8'hAA, 1'b1, 1'b0, 1'b0};

    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.op_a     = 8'h00;
    bus.op_b     = 8'h00;
    bus.opsel    = 3'd0;
    bus.mode     = 1'b0;
    bus.cin_init = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    chk("reset_result", 64'(bus.result), 64'h00);
    chk("reset_carry", 64'(bus.carry_out), 64'h0);
    chk("reset_done", 64'(bus.done), 64'h0);
    chk("reset_ready", 64'(bus.ready), 64'h1);
    chk("reset_zero", 64'(bus.zero), 64'h0);
    chk("reset_ovf", 64'(bus.ovf), 64'h0);

    for (int i = 0; i < 8; i++) begin
      chk($sformatf("v%0d_ready_before", i), 64'(bus.ready), 64'h1);
      run_op(vecs[i], cycles, s_opsel, s_mode);
      chk($sformatf("v%0d_latency", i), 64'(cycles), 64'd9);
      chk($sformatf("v%0d_slice_opsel", i), 64'(s_opsel), 64'(vecs[i].opsel));
      chk($sformatf("v%0d_slice_mode", i), 64'(s_mode), 64'(vecs[i].mode));
      chk($sformatf("v%0d_result", i), 64'(bus.result), 64'(vecs[i].res));
      chk($sformatf("v%0d_carry", i), 64'(bus.carry_out), 64'(vecs[i].cout));
      chk($sformatf("v%0d_zero", i), 64'(bus.zero), 64'(vecs[i].zero));
      chk($sformatf("v%0d_ovf", i), 64'(bus.ovf), 64'(vecs[i].ovf & OVF_EN));
      tick();
      chk($sformatf("v%0d_done_pulse", i), 64'(bus.done), 64'h0);
      chk($sformatf("v%0d_result_held", i), 64'(bus.result), 64'(vecs[i].res));
    end

    // Start during RUN is ignored.
    bus.op_a = 8'hF0; bus.op_b = 8'h3C; bus.mode = 1'b1; bus.cin_init = 1'b0;
    bus.opsel = 3'd0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    bus.op_a = 8'hFF; bus.op_b = 8'hFF; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    pulses = 0;
    if (bus.done) pulses++;
    begin
      int p2;
      count_done(14, p2);
      pulses += p2;
    end
    chk("busy_start_pulses", 64'(pulses), 64'd1);
    chk("busy_start_result", 64'(bus.result), 64'h30);
    chk("busy_start_ready", 64'(bus.ready), 64'h1);

    // Reset in RUN cycle 4 aborts without a done pulse.
    bus.op_a = 8'hAA; bus.op_b = 8'h55; bus.mode = 1'b0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    tick();
    chk("abort_running", 64'(bus.ready), 64'h0);
    rst_n = 1'b0;
    tick();
    chk("abort_ready", 64'(bus.ready), 64'h1);
    chk("abort_result", 64'(bus.result), 64'h00);
    chk("abort_done", 64'(bus.done), 64'h0);
    rst_n = 1'b1;
    count_done(12, pulses);
    chk("abort_no_done", 64'(pulses), 64'd0);
    chk("abort_result_after", 64'(bus.result), 64'h00);

    // Reset and start on the same edge: nothing accepted.
    bus.op_a = 8'h01; bus.op_b = 8'h01; bus.start = 1'b1; rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.start = 1'b0;
    chk("rst_start_ready", 64'(bus.ready), 64'h1);
    count_done(12, pulses);
    chk("rst_start_no_done", 64'(pulses), 64'd0);
    chk("rst_start_result", 64'(bus.result), 64'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
